// File: rtl/heating_zone_controller.sv
// -----------------------------------------------------------------------------
// heating_zone_controller
//
// Multi-zone heating controller. Each zone runs its own registered FSM
// (OFF / HEAT / HOLD_OFF) with hysteresis, a minimum on time, a fixed
// hold-off time and a presence-hold timer. Heater drive and the
// active-zone count are registered from the next-state decision.
//
// Optional feature macro: HEATING_FROST_PROTECT_EN
//   When defined, a zone below FROST_TEMP heats regardless of presence and
//   window; only ac_cool can stop it while the frost condition holds.
//
// Ports
//   clk         in   1                     system clock, rising edge
//   rst_n       in   1                     asynchronous active-low reset
//   temp        in   NUM_ZONES*TEMP_W      zone z temperature at [z*TEMP_W +: TEMP_W]
//   setpoint    in   TEMP_W                shared turn-on threshold
//   hyst        in   TEMP_W                hysteresis band above setpoint
//   presence    in   NUM_ZONES             motion sensor, 1 = occupied
//   window      in   NUM_ZONES             1 = window open
//   ac_cool     in   1                     1 = AC cooling, inhibits all heating
//   heat_on     out  NUM_ZONES             heater drive, registered
//   zone_state  out  2*NUM_ZONES           zone z state at [2z +: 2]
//                                          (00 OFF, 01 HEAT, 10 HOLD_OFF)
//   active_cnt  out  $clog2(NUM_ZONES+1)   number of zones heating, registered
// -----------------------------------------------------------------------------
module heating_zone_controller #(
    parameter int unsigned NUM_ZONES     = 2,
    parameter int unsigned TEMP_W        = 8,
    parameter int unsigned MIN_ON_CYC    = 4,
    parameter int unsigned MIN_OFF_CYC   = 3,
    parameter int unsigned PRES_HOLD_CYC = 5,
    parameter int unsigned FROST_TEMP    = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_ZONES*TEMP_W-1:0]      temp,
    input  logic [TEMP_W-1:0]                setpoint,
    input  logic [TEMP_W-1:0]                hyst,
    input  logic [NUM_ZONES-1:0]             presence,
    input  logic [NUM_ZONES-1:0]             window,
    input  logic                             ac_cool,
    output logic [NUM_ZONES-1:0]             heat_on,
    output logic [2*NUM_ZONES-1:0]           zone_state,
    output logic [$clog2(NUM_ZONES+1)-1:0]   active_cnt
);

    localparam int unsigned ACT_W  = $clog2(NUM_ZONES + 1);
    localparam int unsigned ON_W   = (MIN_ON_CYC  > 1) ? $clog2(MIN_ON_CYC)  : 1;
    localparam int unsigned OFF_W  = (MIN_OFF_CYC > 1) ? $clog2(MIN_OFF_CYC) : 1;
    localparam int unsigned PRES_W = (PRES_HOLD_CYC > 0) ? $clog2(PRES_HOLD_CYC + 1) : 1;

    localparam logic [ON_W-1:0]   ON_MAX    = ON_W'(MIN_ON_CYC - 1);
    localparam logic [OFF_W-1:0]  OFF_MAX   = OFF_W'(MIN_OFF_CYC - 1);
    localparam logic [PRES_W-1:0] PRES_LOAD = PRES_W'(PRES_HOLD_CYC);
    localparam logic [TEMP_W-1:0] FROST_T   = TEMP_W'(FROST_TEMP);

`ifdef HEATING_FROST_PROTECT_EN
    localparam logic FROST_EN = 1'b1;
`else
    localparam logic FROST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_HEAT = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // Upper hysteresis threshold, one bit wider so setpoint+hyst never wraps.
    logic [TEMP_W:0]        w_hi;
    logic [NUM_ZONES-1:0]   w_heat_nxt;
    logic [ACT_W-1:0]       w_active_nxt;
    logic [NUM_ZONES-1:0]   r_heat_on;
    logic [ACT_W-1:0]       r_active_cnt;

    assign w_hi = {1'b0, setpoint} + {1'b0, hyst};

    for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
        state_t             r_state;
        state_t             w_state_nxt;
        logic [ON_W-1:0]    r_on_cnt;
        logic [ON_W-1:0]    w_on_cnt_nxt;
        logic [OFF_W-1:0]   r_off_cnt;
        logic [OFF_W-1:0]   w_off_cnt_nxt;
        logic [PRES_W-1:0]  r_pres_cnt;
        logic [PRES_W-1:0]  w_pres_cnt_nxt;
        logic [TEMP_W-1:0]  w_temp;
        logic               w_cold;
        logic               w_warm;
        logic               w_pres_s;
        logic               w_abort;
        logic               w_frost;
        logic               w_start;
        logic               w_kill;
        logic               w_exit_ok;

        assign w_temp   = temp[g*TEMP_W +: TEMP_W];
        assign w_cold   = (w_temp < setpoint);
        assign w_warm   = ({1'b0, w_temp} >= w_hi);
        assign w_pres_s = presence[g] | (r_pres_cnt != '0);
        assign w_abort  = window[g] | ac_cool;
        assign w_frost  = FROST_EN & (w_temp < FROST_T);

        // Frost overrides presence and window: it can start heating on its
        // own, narrows the abort set to ac_cool, and leaves warm as the only
        // normal exit while it persists.
        assign w_start   = (w_cold & w_pres_s & ~w_abort) | (w_frost & ~ac_cool);
        assign w_kill    = w_frost ? ac_cool : w_abort;
        assign w_exit_ok = (r_on_cnt >= ON_MAX) & (w_warm | (~w_pres_s & ~w_frost));

        always_comb begin
            w_pres_cnt_nxt = r_pres_cnt;
            if (presence[g]) begin
                w_pres_cnt_nxt = PRES_LOAD;
            end else if (r_pres_cnt != '0) begin
                w_pres_cnt_nxt = r_pres_cnt - 1'b1;
            end
        end

        always_comb begin
            w_state_nxt   = r_state;
            w_on_cnt_nxt  = r_on_cnt;
            w_off_cnt_nxt = r_off_cnt;
            case (r_state)
                ST_OFF: begin
                    if (w_start) begin
                        w_state_nxt  = ST_HEAT;
                        w_on_cnt_nxt = '0;
                    end
                end
                ST_HEAT: begin
                    if (w_kill || w_exit_ok) begin
                        w_state_nxt   = ST_HOLD;
                        w_off_cnt_nxt = '0;
                    end else if (r_on_cnt < ON_MAX) begin
                        w_on_cnt_nxt = r_on_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_off_cnt == OFF_MAX) begin
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_off_cnt_nxt = r_off_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= ST_OFF;
                r_on_cnt   <= '0;
                r_off_cnt  <= '0;
                r_pres_cnt <= '0;
            end else begin
                r_state    <= w_state_nxt;
                r_on_cnt   <= w_on_cnt_nxt;
                r_off_cnt  <= w_off_cnt_nxt;
                r_pres_cnt <= w_pres_cnt_nxt;
            end
        end

        assign w_heat_nxt[g]       = (w_state_nxt == ST_HEAT);
        assign zone_state[2*g +: 2] = r_state;
    end

    always_comb begin
        w_active_nxt = '0;
        for (int unsigned i = 0; i < NUM_ZONES; i++) begin
            w_active_nxt = w_active_nxt + ACT_W'(w_heat_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_heat_on    <= '0;
            r_active_cnt <= '0;
        end else begin
            r_heat_on    <= w_heat_nxt;
            r_active_cnt <= w_active_nxt;
        end
    end

    assign heat_on    = r_heat_on;
    assign active_cnt = r_active_cnt;

endmodule

// File: tb/tb_heating_zone_controller.sv
// -----------------------------------------------------------------------------
// tb_heating_zone_controller
//
// Directed, table-driven bench for heating_zone_controller with
// NUM_ZONES=2, TEMP_W=8, MIN_ON=4, MIN_OFF=3, PRES_HOLD=5, setpoint=20.
// Each table row is the input set applied before one rising edge and the
// outputs expected after it. Reset, hysteresis-free threshold and frost
// behaviour are covered by short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_heating_zone_controller;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] temp;
    logic [7:0]  setpoint;
    logic [7:0]  hyst;
    logic [1:0]  presence;
    logic [1:0]  window;
    logic        ac_cool;
    logic [1:0]  heat_on;
    logic [3:0]  zone_state;
    logic [1:0]  active_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] t0;
        logic [7:0] t1;
        logic [1:0] pres;
        logic [1:0] win;
        logic       ac;
        logic [1:0] eh;
        logic [3:0] es;
        logic [1:0] ec;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    heating_zone_controller #(
        .NUM_ZONES    (2),
        .TEMP_W       (8),
        .MIN_ON_CYC   (4),
        .MIN_OFF_CYC  (3),
        .PRES_HOLD_CYC(5),
        .FROST_TEMP   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .temp      (temp),
        .setpoint  (setpoint),
        .hyst      (hyst),
        .presence  (presence),
        .window    (window),
        .ac_cool   (ac_cool),
        .heat_on   (heat_on),
        .zone_state(zone_state),
        .active_cnt(active_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] eh,
                         input logic [3:0] es, input logic [1:0] ec);
        n_checks++;
        if (heat_on !== eh) begin
            n_fail++;
            $display("FAIL %s heat_on got %b expected %b", name, heat_on, eh);
        end
        n_checks++;
        if (zone_state !== es) begin
            n_fail++;
            $display("FAIL %s zone_state got %b expected %b", name, zone_state, es);
        end
        n_checks++;
        if (active_cnt !== ec) begin
            n_fail++;
            $display("FAIL %s active_cnt got %0d expected %0d", name, active_cnt, ec);
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass,
    // return at the following falling edge ready for sampling.
    task automatic step(input logic [7:0] t0, input logic [7:0] t1,
                        input logic [1:0] pres, input logic [1:0] win,
                        input logic ac);
        temp     = {t1, t0};
        presence = pres;
        window   = win;
        ac_cool  = ac;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [7:0] t0, input logic [7:0] t1,
                                input logic [1:0] pres, input logic [1:0] win,
                                input logic ac, input logic [1:0] eh,
                                input logic [3:0] es, input logic [1:0] ec);
        vec_t v;
        v.t0 = t0; v.t1 = t1; v.pres = pres; v.win = win; v.ac = ac;
        v.eh = eh; v.es = es; v.ec = ec;
        return v;
    endfunction

    initial begin
        // zone 0: heat on, warm exit after min-on, hold-off, then OFF
        vecs[0]  = mk(18, 25, 2'b01, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[1]  = mk(22, 25, 2'b01, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[2]  = mk(22, 25, 2'b01, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[3]  = mk(22, 25, 2'b01, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[4]  = mk(22, 25, 2'b01, 2'b00, 0, 2'b00, 4'b0010, 2'd0);
        vecs[5]  = mk(22, 25, 2'b01, 2'b00, 0, 2'b00, 4'b0010, 2'd0);
        vecs[6]  = mk(22, 25, 2'b01, 2'b00, 0, 2'b00, 4'b0010, 2'd0);
        vecs[7]  = mk(22, 25, 2'b01, 2'b00, 0, 2'b00, 4'b0000, 2'd0);
        // window abort, hold-off ignores cold, window blocks restart
        vecs[8]  = mk(18, 25, 2'b01, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[9]  = mk(18, 25, 2'b01, 2'b01, 0, 2'b00, 4'b0010, 2'd0);
        vecs[10] = mk(18, 25, 2'b01, 2'b01, 0, 2'b00, 4'b0010, 2'd0);
        vecs[11] = mk(18, 25, 2'b01, 2'b01, 0, 2'b00, 4'b0010, 2'd0);
        vecs[12] = mk(18, 25, 2'b01, 2'b01, 0, 2'b00, 4'b0000, 2'd0);
        vecs[13] = mk(18, 25, 2'b01, 2'b01, 0, 2'b00, 4'b0000, 2'd0);
        vecs[14] = mk(18, 25, 2'b01, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        // presence drops, temp=21 inside band: held 5 cycles, then exit
        vecs[15] = mk(21, 25, 2'b00, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[16] = mk(21, 25, 2'b00, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[17] = mk(21, 25, 2'b00, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[18] = mk(21, 25, 2'b00, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[19] = mk(21, 25, 2'b00, 2'b00, 0, 2'b01, 4'b0001, 2'd1);
        vecs[20] = mk(21, 25, 2'b00, 2'b00, 0, 2'b00, 4'b0010, 2'd0);
        vecs[21] = mk(21, 25, 2'b00, 2'b00, 0, 2'b00, 4'b0010, 2'd0);
        vecs[22] = mk(21, 25, 2'b00, 2'b00, 0, 2'b00, 4'b0010, 2'd0);
        vecs[23] = mk(21, 25, 2'b00, 2'b00, 0, 2'b00, 4'b0000, 2'd0);
        // temp == setpoint is not cold
        vecs[24] = mk(20, 25, 2'b01, 2'b00, 0, 2'b00, 4'b0000, 2'd0);
        // both zones heat, ac_cool drops both, reheat, independent window
        vecs[25] = mk(18, 15, 2'b11, 2'b00, 0, 2'b11, 4'b0101, 2'd2);
        vecs[26] = mk(18, 15, 2'b11, 2'b00, 1, 2'b00, 4'b1010, 2'd0);
        vecs[27] = mk(18, 15, 2'b11, 2'b00, 0, 2'b00, 4'b1010, 2'd0);
        vecs[28] = mk(18, 15, 2'b11, 2'b00, 0, 2'b00, 4'b1010, 2'd0);
        vecs[29] = mk(18, 15, 2'b11, 2'b00, 0, 2'b00, 4'b0000, 2'd0);
        vecs[30] = mk(18, 15, 2'b11, 2'b00, 0, 2'b11, 4'b0101, 2'd2);
        vecs[31] = mk(18, 15, 2'b11, 2'b10, 0, 2'b01, 4'b1001, 2'd1);

        temp     = {8'd25, 8'd25};
        setpoint = 8'd20;
        hyst     = 8'd2;
        presence = 2'b00;
        window   = 2'b00;
        ac_cool  = 1'b0;

        #1 rst_n = 1'b0;
        #1 check("reset_initial", 2'b00, 4'b0000, 2'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].t0, vecs[i].t1, vecs[i].pres, vecs[i].win, vecs[i].ac);
            check($sformatf("vec%0d", i), vecs[i].eh, vecs[i].es, vecs[i].ec);
        end

        // Asynchronous reset while zone 0 heats: outputs clear with no edge.
        #2 rst_n = 1'b0;
        #1 check("async_reset", 2'b00, 4'b0000, 2'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Presence-hold counter was loaded before reset; it must be cleared.
        step(18, 25, 2'b00, 2'b00, 0);
        check("pres_cleared", 2'b00, 4'b0000, 2'd0);

        // hyst=0: plain threshold, temp==setpoint counts as warm.
        hyst = 8'd0;
        step(19, 25, 2'b01, 2'b00, 0);
        check("h0_start", 2'b01, 4'b0001, 2'd1);
        step(20, 25, 2'b01, 2'b00, 0);
        step(20, 25, 2'b01, 2'b00, 0);
        step(20, 25, 2'b01, 2'b00, 0);
        check("h0_minon", 2'b01, 4'b0001, 2'd1);
        step(20, 25, 2'b01, 2'b00, 0);
        check("h0_exit", 2'b00, 4'b0010, 2'd0);
        hyst = 8'd2;
        do_reset();

        // Frost on zone 1 with no presence and an open window.
        step(25, 3, 2'b00, 2'b10, 0);
`ifdef HEATING_FROST_PROTECT_EN
        check("frost_start", 2'b10, 4'b0100, 2'd1);
`else
        check("frost_start", 2'b00, 4'b0000, 2'd0);
`endif
        step(25, 3, 2'b00, 2'b10, 0);
`ifdef HEATING_FROST_PROTECT_EN
        check("frost_hold", 2'b10, 4'b0100, 2'd1);
`else
        check("frost_hold", 2'b00, 4'b0000, 2'd0);
`endif
        step(25, 3, 2'b00, 2'b10, 1);
`ifdef HEATING_FROST_PROTECT_EN
        check("frost_ac", 2'b00, 4'b1000, 2'd0);
`else
        check("frost_ac", 2'b00, 4'b0000, 2'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
